cpu_bus_arb: RTL and testbench

Two-master to one-slave bus arbiter placed directly downstream of the CPU wrapper. It merges the CPU instruction port (`icpu_*`) and data port (`dcpu_*`) onto a single memory-side port (`mem_*`) that feeds the SDRAM/ROM controller. It grants one master at a time, routes `ack` and read data back only to the granted master, and provides a watchdog that terminates hung transfers.

---
 rtl/cpu_bus_arb_if.sv | 16 +
 rtl/cpu_bus_arb.sv | 168 ++++++++++++++++
 tb/tb_cpu_bus_arb.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arb_if.sv
// Single-beat CPU-side bus: request, write enable, byte selects, address and write data
// from the master; read data and a one-cycle acknowledge from the slave.
interface cpu_bus_arb_if #(
  parameter int AW = 24
) ();
  logic          cs;
  logic          we;
  logic [3:0]    sel;
  logic [AW-1:0] adr;
  logic [31:0]   dat_w;
  logic [31:0]   dat_r;
  logic          ack;

  modport master (output cs, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cs, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/cpu_bus_arb.sv
// Two-master to one-slave arbiter merging the CPU instruction and data ports onto the
// memory port, with an optional watchdog that terminates hung transfers.
module cpu_bus_arb #(
  parameter int AW      = 24,
  parameter int DPRIO   = 0,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  cpu_bus_arb_if.slave  icpu,
  cpu_bus_arb_if.slave  dcpu,
  cpu_bus_arb_if.master mem,
  output logic          bus_err,
  output logic [1:0]    gnt
);
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  localparam bit              WD_EN  = (TIMEOUT > 0);
  localparam logic [TO_W-1:0] WD_LIM = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TO_W-1:0] WD_ONE = TO_W'(1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic            last_d_r;
  logic [TO_W-1:0] wd_cnt_r;
  logic            bus_err_r;
  logic            timeout_s;
  logic            mem_cs_s;
  logic            mem_we_s;
  logic [3:0]      mem_sel_s;
  logic [AW-1:0]   mem_adr_s;
  logic [31:0]     mem_dat_w_s;
  logic            i_ack_s;
  logic            d_ack_s;
  logic [31:0]     i_dat_s;
  logic [31:0]     d_dat_s;

  // Watchdog expiry: the last permitted grant cycle passes without a slave ack
  always_comb begin
    timeout_s = 1'b0;
    if (WD_EN && (state_r != IDLE) && !mem.ack && (wd_cnt_r == WD_LIM)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next state: grant decision in IDLE, single exit from a grant on ack or watchdog
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (icpu.cs && dcpu.cs) begin
          if (DPRIO != 0) begin
            state_nxt_s = GNT_D;
          end else if (last_d_r) begin
            state_nxt_s = GNT_I;
          end else begin
            state_nxt_s = GNT_D;
          end
        end else if (icpu.cs) begin
          state_nxt_s = GNT_I;
        end else if (dcpu.cs) begin
          state_nxt_s = GNT_D;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (mem.ack || timeout_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant state, round-robin history, per-transfer watchdog count and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      last_d_r  <= 1'b0;
      wd_cnt_r  <= {TO_W{1'b0}};
      bus_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == IDLE) && (state_nxt_s != IDLE)) begin
        last_d_r <= (state_nxt_s == GNT_D);
      end else begin
        last_d_r <= last_d_r;
      end
      // Held at zero in IDLE so every grant starts counting from a clean slate
      if (state_r == IDLE) begin
        wd_cnt_r <= {TO_W{1'b0}};
      end else if (!mem.ack) begin
        wd_cnt_r <= wd_cnt_r + WD_ONE;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      bus_err_r <= bus_err_r | timeout_s;
    end
  end

  // Memory-side mux: granted master drives the slave, data master is the idle default
  always_comb begin
    mem_cs_s = (state_r != IDLE);
    if (state_r == GNT_I) begin
      mem_we_s    = icpu.we;
      mem_sel_s   = icpu.sel;
      mem_adr_s   = icpu.adr;
      mem_dat_w_s = icpu.dat_w;
    end else begin
      mem_we_s    = dcpu.we;
      mem_sel_s   = dcpu.sel;
      mem_adr_s   = dcpu.adr;
      mem_dat_w_s = dcpu.dat_w;
    end
  end

  // Ack goes only to the granted master; a watchdog ack returns zero data
  always_comb begin
    i_ack_s = 1'b0;
    d_ack_s = 1'b0;
    i_dat_s = mem.dat_r;
    d_dat_s = mem.dat_r;
    case (state_r)
      GNT_I: begin
        i_ack_s = mem.ack | timeout_s;
        if (timeout_s) begin
          i_dat_s = 32'h0000_0000;
        end else begin
          i_dat_s = mem.dat_r;
        end
      end
      GNT_D: begin
        d_ack_s = mem.ack | timeout_s;
        if (timeout_s) begin
          d_dat_s = 32'h0000_0000;
        end else begin
          d_dat_s = mem.dat_r;
        end
      end
      default: begin
        i_ack_s = 1'b0;
        d_ack_s = 1'b0;
      end
    endcase
  end

  assign mem.cs     = mem_cs_s;
  assign mem.we     = mem_we_s;
  assign mem.sel    = mem_sel_s;
  assign mem.adr    = mem_adr_s;
  assign mem.dat_w  = mem_dat_w_s;
  assign icpu.ack   = i_ack_s;
  assign icpu.dat_r = i_dat_s;
  assign dcpu.ack   = d_ack_s;
  assign dcpu.dat_r = d_dat_s;
  assign bus_err    = bus_err_r;
  assign gnt        = state_r;
endmodule

// File: tb/tb_cpu_bus_arb.sv
// Directed bench for cpu_bus_arb: round-robin/watchdog instance and a fixed-priority
// instance share one stimulus set; expected results flow through scoreboard queues.
module tb_cpu_bus_arb;
  localparam int AW = 24;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1, dsel;
  logic i_cs, i_we, d_cs, d_we, m_ack;
  logic [3:0] i_sel, d_sel;
  logic [AW-1:0] i_adr, d_adr;
  logic [31:0] i_dw, d_dw, m_dr;
  logic berr0, berr1;
  logic [1:0] gnt0, gnt1;

  logic mcs_s, mwe_s, iack_s, dack_s, berr_s;
  logic [3:0] msel_s;
  logic [AW-1:0] madr_s;
  logic [31:0] mdw_s, idr_s, ddr_s;
  logic [1:0] gnt_s;

  int n_chk = 0;
  int n_err = 0;
  exp_t rd_q[$];
  logic [1:0] gnt_q[$];

  always #5 clk = ~clk;

  cpu_bus_arb_if #(.AW(AW)) i0 ();
  cpu_bus_arb_if #(.AW(AW)) d0 ();
  cpu_bus_arb_if #(.AW(AW)) m0 ();
  cpu_bus_arb_if #(.AW(AW)) i1 ();
  cpu_bus_arb_if #(.AW(AW)) d1 ();
  cpu_bus_arb_if #(.AW(AW)) m1 ();

  assign i0.cs = i_cs;  assign i0.we = i_we;  assign i0.sel = i_sel;  assign i0.adr = i_adr;  assign i0.dat_w = i_dw;
  assign d0.cs = d_cs;  assign d0.we = d_we;  assign d0.sel = d_sel;  assign d0.adr = d_adr;  assign d0.dat_w = d_dw;
  assign m0.ack = m_ack; assign m0.dat_r = m_dr;
  assign i1.cs = i_cs;  assign i1.we = i_we;  assign i1.sel = i_sel;  assign i1.adr = i_adr;  assign i1.dat_w = i_dw;
  assign d1.cs = d_cs;  assign d1.we = d_we;  assign d1.sel = d_sel;  assign d1.adr = d_adr;  assign d1.dat_w = d_dw;
  assign m1.ack = m_ack; assign m1.dat_r = m_dr;

  cpu_bus_arb #(.AW(AW), .DPRIO(0), .TIMEOUT(16), .TO_W(8)) dut0 (
    .clk(clk), .rst(rst0), .icpu(i0), .dcpu(d0), .mem(m0), .bus_err(berr0), .gnt(gnt0)
  );
  cpu_bus_arb #(.AW(AW), .DPRIO(1), .TIMEOUT(0), .TO_W(8)) dut1 (
    .clk(clk), .rst(rst1), .icpu(i1), .dcpu(d1), .mem(m1), .bus_err(berr1), .gnt(gnt1)
  );

  assign mcs_s  = dsel ? m1.cs    : m0.cs;
  assign mwe_s  = dsel ? m1.we    : m0.we;
  assign msel_s = dsel ? m1.sel   : m0.sel;
  assign madr_s = dsel ? m1.adr   : m0.adr;
  assign mdw_s  = dsel ? m1.dat_w : m0.dat_w;
  assign iack_s = dsel ? i1.ack   : i0.ack;
  assign dack_s = dsel ? d1.ack   : d0.ack;
  assign idr_s  = dsel ? i1.dat_r : i0.dat_r;
  assign ddr_s  = dsel ? d1.dat_r : d0.dat_r;
  assign berr_s = dsel ? berr1    : berr0;
  assign gnt_s  = dsel ? gnt1     : gnt0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [1:0] who, input logic [31:0] dat);
    exp_t e;
    e.who = who;
    e.dat = dat;
    rd_q.push_back(e);
  endtask

  task automatic pulse_rst(input bit which);
    @(negedge clk);
    i_cs = 1'b0; d_cs = 1'b0; m_ack = 1'b0;
    if (which) rst1 = 1'b1; else rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
  endtask

  // Instruction read; slave acks on grant cycle ack_at (0 = never)
  task automatic run_i(input string tag, input int ack_at, input logic [31:0] rdat,
                       input logic [31:0] exp_dat, output int cs_len, output int ack_n);
    bit done;
    exp_t e;
    cs_len = 0; ack_n = 0; done = 1'b0;
    @(negedge clk);
    i_cs = 1'b1; i_we = 1'b0; i_adr = 24'h00_4000; m_ack = 1'b0; m_dr = rdat;
    push_rd(2'b01, exp_dat);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      m_ack = 1'b0;
      #1;
      if (mcs_s) begin
        cs_len++;
        if (cs_len == ack_at) m_ack = 1'b1;
      end
      #1;
      if (iack_s) begin
        ack_n = cs_len;
        done = 1'b1;
        i_cs = 1'b0;
        chk({tag, " d_ack"}, dack_s, 1'b0);
        if (rd_q.size() > 0) begin
          e = rd_q.pop_front();
          chk({tag, " rdata"}, idr_s, e.dat);
        end
      end
    end
    chk({tag, " ack seen"}, done, 1'b1);
  endtask

  // Both masters contend; slave acks on the second cycle of every grant
  task automatic contend(input string tag, input bit d_hold, input int ncyc);
    logic mcs_prev, i_ack_prev, d_ack_prev, seen_end;
    logic [1:0] exp_g;
    int blen, gap;
    mcs_prev = 1'b0; i_ack_prev = 1'b0; d_ack_prev = 1'b0; seen_end = 1'b0;
    exp_g = 2'b00; blen = 0; gap = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      i_cs = !i_ack_prev;
      d_cs = d_hold ? 1'b1 : !d_ack_prev;
      i_we = 1'b0; d_we = 1'b0;
      m_ack = 1'b0;
      #1;
      m_ack = mcs_s && mcs_prev;
      m_dr = 32'hA500_0000 | 32'(c);
      #1;
      if (mcs_s && !mcs_prev) begin
        if (gnt_q.size() > 0) begin
          exp_g = gnt_q.pop_front();
          chk({tag, " grant"}, gnt_s, exp_g);
        end
        if (seen_end) chk({tag, " idle gap"}, gap, 1);
        blen = 0;
      end
      if (mcs_s) begin
        blen++;
      end else if (mcs_prev) begin
        chk({tag, " burst len"}, blen, 2);
        seen_end = 1'b1;
        gap = 1;
      end else begin
        gap++;
      end
      if (m_ack) begin
        chk({tag, " i_ack route"}, iack_s, exp_g == 2'b01);
        chk({tag, " d_ack route"}, dack_s, exp_g == 2'b10);
        chk({tag, " rdata"}, (exp_g == 2'b01) ? idr_s : ddr_s, m_dr);
      end
      i_ack_prev = iack_s;
      d_ack_prev = dack_s;
      mcs_prev = mcs_s;
    end
    i_cs = 1'b0; d_cs = 1'b0; m_ack = 1'b0;
    chk({tag, " grants drained"}, gnt_q.size(), 0);
  endtask

  initial begin
    exp_t e;
    int cs_len, ack_n;
    rst0 = 1'b1; rst1 = 1'b1; dsel = 1'b0;
    i_cs = 1'b0; i_we = 1'b0; i_sel = 4'h0; i_adr = 24'h0; i_dw = 32'h0;
    d_cs = 1'b0; d_we = 1'b0; d_sel = 4'h0; d_adr = 24'h0; d_dw = 32'h0;
    m_ack = 1'b0; m_dr = 32'h0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      dsel = (u == 1);
      #1;
      chk("reset gnt", gnt_s, 2'b00);
      chk("reset mem_cs", mcs_s, 1'b0);
      chk("reset i_ack", iack_s, 1'b0);
      chk("reset d_ack", dack_s, 1'b0);
      chk("reset bus_err", berr_s, 1'b0);
    end
    dsel = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;

    // Data read, slave acks three cycles after mem_cs rises
    @(negedge clk);
    d_cs = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_adr = 24'h00_ABCD; m_dr = 32'h1234_5678; m_ack = 1'b0;
    push_rd(2'b10, 32'h1234_5678);
    #1;
    chk("A req latency", mcs_s, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      m_ack = (k == 4);
      #1;
      chk("A gnt", gnt_s, 2'b10);
      chk("A mem_adr", madr_s, 24'h00_ABCD);
      chk("A mem_we", mwe_s, 1'b0);
      chk("A i_ack", iack_s, 1'b0);
      if (k < 4) begin
        chk("A d_ack early", dack_s, 1'b0);
      end else if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("A d_ack", dack_s, e.who == 2'b10);
        chk("A rdata", ddr_s, e.dat);
      end
    end
    @(negedge clk);
    d_cs = 1'b0; m_ack = 1'b0;
    #1;
    chk("A d_ack pulse", dack_s, 1'b0);
    chk("A idle gnt", gnt_s, 2'b00);

    // Data write held across a three-cycle grant
    @(negedge clk);
    d_cs = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_dw = 32'hCAFE_F00D; d_adr = 24'h00_0123;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_ack = (k == 2);
      #1;
      chk("W gnt", gnt_s, 2'b10);
      chk("W mem_we", mwe_s, 1'b1);
      chk("W mem_sel", msel_s, 4'b0011);
      chk("W mem_dat_w", mdw_s, 32'hCAFE_F00D);
      chk("W d_ack", dack_s, k == 2);
    end
    @(negedge clk);
    d_cs = 1'b0; d_we = 1'b0; m_ack = 1'b0;
    #1;
    chk("W release", mcs_s, 1'b0);

    // Real ack on the final watchdog cycle wins over the timeout
    run_i("P", 16, 32'h5A5A_5A5A, 32'h5A5A_5A5A, cs_len, ack_n);
    chk("P ack cycle", ack_n, 16);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    chk("P bus_err", berr_s, 1'b0);

    // Slave never acks: watchdog ends the grant with zero data
    run_i("T", 0, 32'hDEAD_BEEF, 32'h0000_0000, cs_len, ack_n);
    chk("T ack cycle", ack_n, 16);
    chk("T cs length", cs_len, 16);
    @(negedge clk);
    m_ack = 1'b1;
    #1;
    chk("T bus_err", berr_s, 1'b1);
    chk("T late i_ack", iack_s, 1'b0);
    chk("T late d_ack", dack_s, 1'b0);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    chk("T bus_err sticky", berr_s, 1'b1);
    chk("T idle mem_cs", mcs_s, 1'b0);

    // Reset in the middle of an instruction grant
    @(negedge clk);
    i_cs = 1'b1; i_adr = 24'h00_0800;
    @(negedge clk);
    #1;
    chk("R gnt before", gnt_s, 2'b01);
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0; m_ack = 1'b1;
    #1;
    chk("R mem_cs", mcs_s, 1'b0);
    chk("R gnt", gnt_s, 2'b00);
    chk("R bus_err", berr_s, 1'b0);
    chk("R i_ack", iack_s, 1'b0);
    @(negedge clk);
    m_ack = 1'b0;
    #1;
    chk("R regrant", gnt_s, 2'b01);
    @(negedge clk);
    m_ack = 1'b1; m_dr = 32'h0BAD_F00D;
    push_rd(2'b01, 32'h0BAD_F00D);
    #1;
    chk("R i_ack", iack_s, 1'b1);
    if (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk("R rdata", idr_s, e.dat);
    end
    @(negedge clk);
    i_cs = 1'b0; m_ack = 1'b0;
    #1;
    chk("R done", gnt_s, 2'b00);

    // Round-robin contention from a fresh reset: D, I, D, I
    pulse_rst(1'b0);
    gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
    gnt_q.push_back(2'b10); gnt_q.push_back(2'b01);
    contend("RR", 1'b0, 12);

    // Fixed priority with the data master always requesting: instruction starves
    pulse_rst(1'b1);
    dsel = 1'b1;
    for (int k = 0; k < 4; k++) gnt_q.push_back(2'b10);
    contend("FP", 1'b1, 12);
    dsel = 1'b0;

    chk("read scoreboard drained", rd_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
